// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack, decode valid/ready, execute redirect.
// master = fetch unit side, slave = memory/decode/execute side.
interface instr_fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory port,
// hands instructions to decode over valid/ready, resolves J-type targets and redirects.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  J_OPCODE = 6'b000010
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus_io
);
    localparam int unsigned XLEN = 32;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] saved_pc_q, saved_pc_d;
    logic            drop_q, drop_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            valid_q, valid_d;

    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jump_pc;

    // Redirect targets are forced word-aligned; jump keeps the region bits of pc+4.
    assign redir_pc = bus_io.redirect_pc & ~XLEN'(3);
    assign pc_plus4 = instr_pc_q + XLEN'(4);
    assign jump_pc  = {pc_plus4[31:28], instr_q[25:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            saved_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
            req_q      <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            saved_pc_q <= saved_pc_d;
            drop_q     <= drop_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        saved_pc_d = saved_pc_q;
        drop_d     = drop_q;
        req_d      = req_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;

        case (state_q)
            ST_FETCH: begin
                req_d = 1'b1;
                // No request on the bus yet (just out of reset): acks are ignored.
                if (!req_q) begin
                    if (bus_io.redirect_valid) pc_d = redir_pc;
                end else if (bus_io.imem_ack) begin
                    if (bus_io.redirect_valid) begin
                        pc_d   = redir_pc;
                        drop_d = 1'b0;
                    end else if (drop_q) begin
                        pc_d   = saved_pc_q;
                        drop_d = 1'b0;
                    end else begin
                        instr_d    = bus_io.imem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        req_d      = 1'b0;
                        state_d    = ST_HOLD;
                    end
                end else if (bus_io.redirect_valid) begin
                    // Address must stay stable until ack; remember the target instead.
                    saved_pc_d = redir_pc;
                    drop_d     = 1'b1;
                end
            end
            ST_HOLD: begin
                req_d = 1'b0;
                if (bus_io.redirect_valid) begin
                    valid_d = 1'b0;
                    pc_d    = redir_pc;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end else if (bus_io.instr_ready) begin
                    valid_d = 1'b0;
                    pc_d    = (instr_q[31:26] == J_OPCODE) ? jump_pc : pc_plus4;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
        endcase
    end

    assign bus_io.imem_req    = req_q;
    assign bus_io.imem_addr   = pc_q;
    assign bus_io.instr       = instr_q;
    assign bus_io.instr_pc    = instr_pc_q;
    assign bus_io.instr_valid = valid_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, jump, stall, redirects, wrap and reset.
module tb_instr_fetch_unit;
    localparam logic [31:0] LW  = 32'h8C08_0004;
    localparam logic [31:0] JMP = 32'h0800_0040;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .J_OPCODE (6'b000010)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample 1 time unit after the rising edge.
    task automatic step(input logic ack, input logic [31:0] rdata, input logic ready,
                        input logic rv, input logic [31:0] rpc);
        bus.imem_ack       = ack;
        bus.imem_rdata     = rdata;
        bus.instr_ready    = ready;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req",   32'(bus.imem_req), 32'd0);
        check_eq("rst_addr",  bus.imem_addr, 32'h0);
        check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("rst_instr", bus.instr, 32'h0);
        rst_n = 1'b1;
        check_eq("rel_req0", 32'(bus.imem_req), 32'd0);

        // 1: sequential lw fetch, zero-wait memory, decode always ready
        step(1'b0, '0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            check_eq("seq_req",  32'(bus.imem_req), 32'd1);
            check_eq("seq_addr", bus.imem_addr, 32'(4 * i));
            step(1'b1, LW, 1'b1, 1'b0, '0);
            check_eq("seq_valid", 32'(bus.instr_valid), 32'd1);
            check_eq("seq_pc",    bus.instr_pc, 32'(4 * i));
            check_eq("seq_instr", bus.instr, LW);
            check_eq("seq_hreq",  32'(bus.imem_req), 32'd0);
            step(1'b0, '0, 1'b1, 1'b0, '0);
            check_eq("seq_vlow", 32'(bus.instr_valid), 32'd0);
        end

        // 2: J at 0x10 -> target 0x100
        check_eq("j_addr", bus.imem_addr, 32'h10);
        step(1'b1, JMP, 1'b1, 1'b0, '0);
        check_eq("j_instr", bus.instr, JMP);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        check_eq("j_target", bus.imem_addr, 32'h100);
        check_eq("j_req",    32'(bus.imem_req), 32'd1);

        // 3: decode stalls for 5 cycles
        step(1'b1, LW, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, '0);
            check_eq("stall_valid", 32'(bus.instr_valid), 32'd1);
            check_eq("stall_pc",    bus.instr_pc, 32'h100);
            check_eq("stall_instr", bus.instr, LW);
            check_eq("stall_req",   32'(bus.imem_req), 32'd0);
            check_eq("stall_addr",  bus.imem_addr, 32'h100);
        end
        step(1'b0, '0, 1'b1, 1'b0, '0);
        check_eq("resume_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("resume_addr",  bus.imem_addr, 32'h104);

        // 4: 3-cycle memory, redirect in first wait cycle
        step(1'b0, '0, 1'b0, 1'b1, 32'h0000_0203);
        check_eq("rw1_addr", bus.imem_addr, 32'h104);
        check_eq("rw1_req",  32'(bus.imem_req), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, '0);
        check_eq("rw2_addr", bus.imem_addr, 32'h104);
        step(1'b1, 32'h2000_0001, 1'b0, 1'b0, '0);
        check_eq("rw_drop_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("rw_new_addr",   bus.imem_addr, 32'h200);
        check_eq("rw_new_req",    32'(bus.imem_req), 32'd1);

        // 5: redirect in HOLD together with ready squashes the instruction
        step(1'b1, LW, 1'b0, 1'b0, '0);
        check_eq("h_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("h_pc",    bus.instr_pc, 32'h200);
        step(1'b0, '0, 1'b1, 1'b1, 32'h0000_0080);
        check_eq("hr_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("hr_addr",  bus.imem_addr, 32'h80);
        // redirect coinciding with ack in FETCH: rdata discarded
        step(1'b1, LW, 1'b1, 1'b1, 32'hFFFF_FFFE);
        check_eq("fa_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("fa_addr",  bus.imem_addr, 32'hFFFF_FFFC);

        // 6: wrap from 0xFFFF_FFFC, then reset mid-wait
        step(1'b1, LW, 1'b0, 1'b0, '0);
        check_eq("wrap_pc", bus.instr_pc, 32'hFFFF_FFFC);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        check_eq("wrap_addr", bus.imem_addr, 32'h0);
        step(1'b1, LW, 1'b1, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        check_eq("pre_rst_addr", bus.imem_addr, 32'h4);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        check_eq("arst_req",   32'(bus.imem_req), 32'd0);
        check_eq("arst_addr",  bus.imem_addr, 32'h0);
        check_eq("arst_instr", bus.instr, 32'h0);
        check_eq("arst_valid", 32'(bus.instr_valid), 32'd0);
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = LW;
        bus.instr_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, LW, 1'b1, 1'b0, '0);
        check_eq("ign_ack_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("ign_ack_req",   32'(bus.imem_req), 32'd1);
        check_eq("ign_ack_addr",  bus.imem_addr, 32'h0);
        step(1'b1, LW, 1'b1, 1'b0, '0);
        check_eq("post_rst_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("post_rst_pc",    bus.instr_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
